hc165_reader: RTL and testbench

HC165_READER -- requirements
Module: hc165_reader

---
 rtl/hc165_reader.sv | 124 ++++++++++++
 tb/tb_hc165_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc165_reader.sv
// Frame reader for one or more cascaded 165-type parallel-in/serial-out shift registers.
// The register shares clk; this block drives its SH/LD and CLK INH pins and samples qh.
module hc165_reader #(
  parameter int unsigned NUM_BITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                qh,
  output logic                shift_load,
  output logic                clock_in_hibit,
  output logic [NUM_BITS-1:0] data_out,
  output logic                valid,
  output logic                busy
);

  localparam int unsigned CntW  = $clog2(NUM_BITS);
  localparam int unsigned WaitW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(NUM_BITS - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSample,
    StShift,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  // Holds the bits received so far; the final bit is appended straight into data_out.
  logic [NUM_BITS-2:0] shreg_q, shreg_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic                shift_load_q, shift_load_d;
  logic                hibit_q, hibit_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    shreg_d   = shreg_q;
    data_d    = data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      StLoad: begin
        state_d = StSample;
        wait_d  = '0;
      end
      StSample: begin
        if (wait_q == WaitLast) begin
          wait_d = '0;
          if (bit_cnt_q == CntLast) begin
            state_d = StDone;
            data_d  = {shreg_q, qh};
          end else begin
            state_d = StShift;
            shreg_d = {shreg_q[NUM_BITS-3:0], qh};
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StShift: begin
        state_d   = StSample;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Pin levels are decoded from the next state so they are registered alongside it.
    shift_load_d = (state_d != StLoad);
    hibit_d      = !((state_d == StLoad) || (state_d == StShift));
    valid_d      = (state_d == StDone);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      wait_q       <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      shift_load_q <= 1'b1;
      hibit_q      <= 1'b1;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_q       <= wait_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      shift_load_q <= shift_load_d;
      hibit_q      <= hibit_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign shift_load     = shift_load_q;
  assign clock_in_hibit = hibit_q;
  assign data_out       = data_q;
  assign valid          = valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_hc165_reader.sv
// Bench for hc165_reader: three instances (default, SETTLE_CYCLES=3, NUM_BITS=16), each
// attached to a behavioural 165 register model, with a scoreboard-driven monitor.
module tb_hc165_reader;

  localparam int N = 3;

  typedef struct packed {
    int          dut;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [N];
  logic [15:0] pin   [N];
  logic        qh    [N];
  logic        sl    [N];
  logic        hib   [N];
  logic        vld   [N];
  logic        bsy   [N];
  logic [15:0] dout  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int NB = (g == 2) ? 16 : 8;
    localparam int SC = (g == 1) ? 3 : 1;
    logic [NB-1:0] d;
    logic [NB-1:0] sreg = '0;

    hc165_reader #(
      .NUM_BITS      (NB),
      .SETTLE_CYCLES (SC)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start[g]),
      .qh             (qh[g]),
      .shift_load     (sl[g]),
      .clock_in_hibit (hib[g]),
      .data_out       (d),
      .valid          (vld[g]),
      .busy           (bsy[g])
    );

    assign dout[g] = 16'(d);
    assign qh[g]   = sreg[NB-1];

    // Cascaded 165s modelled as one register; pin[NB-1:NB-8] is the device nearest qh.
    always @(posedge clk) begin
      if (!hib[g]) sreg <= sl[g] ? {sreg[NB-2:0], 1'b0} : pin[g][NB-1:0];
    end
  end

  function automatic int nb_of(input int g);
    return (g == 2) ? 16 : 8;
  endfunction

  function automatic int lat_of(input int g);
    int sc;
    sc = (g == 1) ? 3 : 1;
    return 1 + nb_of(g) * sc + nb_of(g) - 1;
  endfunction

  function automatic int frames_of(input int g);
    return (g == 0) ? 6 : 1;
  endfunction

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   acc [N] = '{-1, -1, -1};
  logic done = 1'b0;

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at edge %0d", name, g, act, exp, edge_cnt);
    end
  endtask

  // Edge counter and start-accept timestamps (pre-edge values of start/busy).
  always @(posedge clk) begin
    edge_cnt++;
    for (int g = 0; g < N; g++) begin
      if (rst_n === 1'b1 && start[g] === 1'b1 && bsy[g] === 1'b0) acc[g] = edge_cnt;
    end
  end

  logic        was_valid [N];
  logic        prev_hib  [N];
  int          lowcnt    [N];
  int          loadcnt   [N];
  int          busy_run  [N];
  int          nvalid    [N] = '{0, 0, 0};
  logic [15:0] hold      [N];
  exp_t        e;

  always @(negedge clk or negedge rst_n) begin
    #1;
    if (rst_n !== 1'b1) begin
      for (int g = 0; g < N; g++) begin
        chk("reset_outputs", g, {27'd0, sl[g], hib[g], vld[g], bsy[g], |dout[g]}, 32'b11000);
        was_valid[g] = 1'b0;
        prev_hib[g]  = 1'b1;
        lowcnt[g]    = 0;
        loadcnt[g]   = 0;
        busy_run[g]  = 0;
        hold[g]      = '0;
      end
    end else begin
      for (int g = 0; g < N; g++) begin
        if (was_valid[g]) chk("busy_fall", g, {30'd0, bsy[g], vld[g]}, 32'd0);
        was_valid[g] = vld[g];
        if (bsy[g] === 1'b1 && edge_cnt == acc[g]) chk("load_state", g, {sl[g], hib[g]}, 32'd0);
        chk("hib_single_cycle", g, {30'd0, prev_hib[g], hib[g]} == 32'd0, 32'd0);
        prev_hib[g] = hib[g];
        if (hib[g] === 1'b0) lowcnt[g]++;
        if (sl[g] === 1'b0) loadcnt[g]++;
        busy_run[g] = (bsy[g] === 1'b1) ? busy_run[g] + 1 : 0;
        if (busy_run[g] > 100) chk("busy_timeout", g, busy_run[g], 100);

        if (vld[g] === 1'b1) begin
          nvalid[g]++;
          if (sb.size() == 0) begin
            chk("unexpected_valid", g, 1, 0);
          end else begin
            e = sb.pop_front();
            chk("valid_dut", g, g, e.dut);
            chk("data_out", g, dout[g], e.data);
            chk("latency", g, edge_cnt - acc[g], lat_of(g));
            chk("hib_pulses", g, lowcnt[g], nb_of(g));
            chk("load_pulses", g, loadcnt[g], 1);
            hold[g] = e.data;
          end
          lowcnt[g]  = 0;
          loadcnt[g] = 0;
        end else begin
          chk("data_stable", g, dout[g], hold[g]);
        end
      end

      if (done) begin
        chk("scoreboard_empty", 0, sb.size(), 0);
        for (int g = 0; g < N; g++) chk("frame_count", g, nvalid[g], frames_of(g));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (edge_cnt > 20000) begin
        errors++;
        $display("FAIL watchdog: got edge %0d required completion before 20000", edge_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic push(input int g, input logic [15:0] d);
    exp_t x;
    x.dut  = g;
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 400 && bsy[g] !== 1'b0; i++) @(negedge clk);
  endtask

  // Called at a negedge: pulse start for one cycle and wait for the frame to finish.
  task automatic frame(input int g, input logic [15:0] d);
    pin[g] = d;
    push(g, d);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    wait_idle(g);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      start[g] = 1'b0;
      pin[g]   = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    frame(0, 16'h00A5);
    frame(0, 16'h003C);
    frame(0, 16'h00C3);

    // start held high across two full frames: exactly one frame per IDLE visit.
    pin[0] = 16'h0081;
    push(0, 16'h0081);
    push(0, 16'h0081);
    start[0] = 1'b1;
    repeat (36) @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    @(negedge clk);

    // Abort a frame after its third bit has been sampled.
    pin[0] = 16'h0077;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    frame(0, 16'h005A);
    frame(1, 16'h00F0);
    frame(2, 16'hEFBE);

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
